// File: rtl/fp_mul_lane_sched.sv
// Lane-packing scheduler: gathers same-format mantissa multiply requests into one
// SIMD pass of a shared fp_mul_8_16_32 and returns the packed result with per-lane tags.

`ifndef CONFIG_WIDTH
`define CONFIG_WIDTH     3
`define CONFIG_FP32      3'd0
`define CONFIG_FP16      3'd1
`define CONFIG_TF32      3'd2
`define CONFIG_BF16      3'd3
`define CONFIG_FP8_E4M3  3'd4
`define CONFIG_FP8_E5M2  3'd5
`endif

// SIMD mantissa multiplier: 1x24, 2x12 or 4x6 lanes, truncated and normalised per lane.
module fp_mul_8_16_32 #(
    parameter int unsigned WIDTH = 24
) (
    input  logic [WIDTH-1:0]         IN1,
    input  logic [WIDTH-1:0]         IN2,
    input  logic [`CONFIG_WIDTH-1:0] CONFIG,
    output logic [WIDTH-1:0]         OUT,
    output logic [3:0]               OUT_NormBits
);
    localparam int unsigned W2 = WIDTH / 2;
    localparam int unsigned W4 = WIDTH / 4;

    logic [2*WIDTH-1:0] p1;
    logic [WIDTH-1:0]   p2 [2];
    logic [W2-1:0]      p4 [4];

    always_comb begin
        OUT          = '0;
        OUT_NormBits = '0;
        p1 = {{WIDTH{1'b0}}, IN1} * {{WIDTH{1'b0}}, IN2};
        for (int i = 0; i < 2; i++) begin
            p2[i] = {{W2{1'b0}}, IN1[i*W2 +: W2]} * {{W2{1'b0}}, IN2[i*W2 +: W2]};
        end
        for (int i = 0; i < 4; i++) begin
            p4[i] = {{W4{1'b0}}, IN1[i*W4 +: W4]} * {{W4{1'b0}}, IN2[i*W4 +: W4]};
        end
        case (CONFIG)
            `CONFIG_FP16, `CONFIG_TF32: begin
                for (int i = 0; i < 2; i++) begin
                    OUT_NormBits[i]  = p2[i][WIDTH-1];
                    OUT[i*W2 +: W2]  = p2[i][WIDTH-1] ? p2[i][WIDTH-1 -: W2]
                                                      : p2[i][WIDTH-2 -: W2];
                end
            end
            `CONFIG_FP8_E4M3, `CONFIG_FP8_E5M2: begin
                for (int i = 0; i < 4; i++) begin
                    OUT_NormBits[i]  = p4[i][W2-1];
                    OUT[i*W4 +: W4]  = p4[i][W2-1] ? p4[i][W2-1 -: W4] : p4[i][W2-2 -: W4];
                end
            end
            default: begin
                OUT_NormBits[0] = p1[2*WIDTH-1];
                OUT = p1[2*WIDTH-1] ? p1[2*WIDTH-1 -: WIDTH] : p1[2*WIDTH-2 -: WIDTH];
            end
        endcase
    end
endmodule

module fp_mul_lane_sched #(
    parameter int unsigned TAG_W   = 4,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [`CONFIG_WIDTH-1:0] req_cfg,
    input  logic [23:0]              req_a,
    input  logic [23:0]              req_b,
    input  logic [TAG_W-1:0]         req_tag,
    input  logic                     flush,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [`CONFIG_WIDTH-1:0] rsp_cfg,
    output logic [23:0]              rsp_data,
    output logic [3:0]               rsp_norm,
    output logic [3:0]               rsp_mask,
    output logic [4*TAG_W-1:0]       rsp_tags
);
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StFill  = 2'd1;
    localparam logic [1:0] StIssue = 2'd2;
    localparam logic [1:0] StResp  = 2'd3;

    function automatic logic [2:0] lanes_of(input logic [`CONFIG_WIDTH-1:0] cfg);
        case (cfg)
            `CONFIG_FP16, `CONFIG_TF32:          return 3'd2;
            `CONFIG_FP8_E4M3, `CONFIG_FP8_E5M2:  return 3'd4;
            default:                             return 3'd1;
        endcase
    endfunction

    function automatic logic [23:0] place(input logic [23:0] v, input logic [2:0] lanes,
                                          input logic [1:0] idx);
        logic [23:0] r;
        r = '0;
        case (lanes)
            3'd2:    r[idx[0]*12 +: 12] = v[11:0];
            3'd4:    r[idx*6 +: 6]      = v[5:0];
            default: r = v;
        endcase
        return r;
    endfunction

    logic [1:0]               state_q, state_d;
    logic [`CONFIG_WIDTH-1:0] cfg_q, cfg_d;
    logic [2:0]               cnt_q, cnt_d;
    logic [7:0]               idle_q, idle_d;
    logic [23:0]              pack_a_q, pack_a_d, pack_b_q, pack_b_d;
    logic [4*TAG_W-1:0]       tags_q, tags_d;
    logic [3:0]               mask_q, mask_d;
    logic                     ready_en_q;
    logic [`CONFIG_WIDTH-1:0] rsp_cfg_d;
    logic [23:0]              rsp_data_d, mul_out;
    logic [3:0]               rsp_norm_d, rsp_mask_d, mul_norm;
    logic [4*TAG_W-1:0]       rsp_tags_d;
    logic [2:0]               fill_lanes;
    logic                     cfg_match;

    fp_mul_8_16_32 #(
        .WIDTH (24)
    ) u_mul (
        .IN1          (pack_a_q),
        .IN2          (pack_b_q),
        .CONFIG       (cfg_q),
        .OUT          (mul_out),
        .OUT_NormBits (mul_norm)
    );

    assign fill_lanes = lanes_of(cfg_q);
    assign cfg_match  = (req_cfg == cfg_q);
    assign rsp_valid  = (state_q == StResp);

    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        cnt_d      = cnt_q;
        idle_d     = idle_q;
        pack_a_d   = pack_a_q;
        pack_b_d   = pack_b_q;
        tags_d     = tags_q;
        mask_d     = mask_q;
        rsp_cfg_d  = rsp_cfg;
        rsp_data_d = rsp_data;
        rsp_norm_d = rsp_norm;
        rsp_mask_d = rsp_mask;
        rsp_tags_d = rsp_tags;
        req_ready  = 1'b0;
        case (state_q)
            StIdle: begin
                req_ready = ready_en_q;
                if (req_valid && ready_en_q) begin
                    cfg_d    = req_cfg;
                    cnt_d    = 3'd1;
                    idle_d   = '0;
                    pack_a_d = place(req_a, lanes_of(req_cfg), 2'd0);
                    pack_b_d = place(req_b, lanes_of(req_cfg), 2'd0);
                    tags_d   = '0;
                    tags_d[TAG_W-1:0] = req_tag;
                    mask_d   = 4'b0001;
                    state_d  = (lanes_of(req_cfg) == 3'd1) ? StIssue : StFill;
                end
            end
            StFill: begin
                // A mismatched format is stalled here and picked up again from IDLE.
                req_ready = !req_valid || cfg_match;
                if (req_valid && cfg_match) begin
                    pack_a_d = pack_a_q | place(req_a, fill_lanes, cnt_q[1:0]);
                    pack_b_d = pack_b_q | place(req_b, fill_lanes, cnt_q[1:0]);
                    tags_d[cnt_q[1:0]*TAG_W +: TAG_W] = req_tag;
                    mask_d[cnt_q[1:0]] = 1'b1;
                    cnt_d  = cnt_q + 3'd1;
                    idle_d = '0;
                    if (cnt_d == fill_lanes || flush) state_d = StIssue;
                end else begin
                    idle_d = idle_q + 8'd1;
                    if (req_valid || flush || idle_q == 8'(TIMEOUT)) state_d = StIssue;
                end
            end
            StIssue: begin
                rsp_cfg_d  = cfg_q;
                rsp_data_d = mul_out;
                rsp_norm_d = mul_norm;
                rsp_mask_d = mask_q;
                rsp_tags_d = tags_q;
                state_d    = StResp;
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d  = StIdle;
                    cfg_d    = '0;
                    cnt_d    = '0;
                    idle_d   = '0;
                    pack_a_d = '0;
                    pack_b_d = '0;
                    tags_d   = '0;
                    mask_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cfg_q      <= '0;
            cnt_q      <= '0;
            idle_q     <= '0;
            pack_a_q   <= '0;
            pack_b_q   <= '0;
            tags_q     <= '0;
            mask_q     <= '0;
            ready_en_q <= 1'b0;
            rsp_cfg    <= '0;
            rsp_data   <= '0;
            rsp_norm   <= '0;
            rsp_mask   <= '0;
            rsp_tags   <= '0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            cnt_q      <= cnt_d;
            idle_q     <= idle_d;
            pack_a_q   <= pack_a_d;
            pack_b_q   <= pack_b_d;
            tags_q     <= tags_d;
            mask_q     <= mask_d;
            ready_en_q <= 1'b1;
            rsp_cfg    <= rsp_cfg_d;
            rsp_data   <= rsp_data_d;
            rsp_norm   <= rsp_norm_d;
            rsp_mask   <= rsp_mask_d;
            rsp_tags   <= rsp_tags_d;
        end
    end
endmodule
